lamp_reader: RTL and testbench

LAMP_READER -- requirements
Module: lamp_reader

---
 rtl/lamp_reader.sv | 180 ++++++++++++++++++
 tb/tb_lamp_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lamp_reader.sv
// lamp_reader: turns one-hot lamp strobes from the cipher path into an ASCII stream.
//
// Each lamp_strobe with exactly one lamp lit writes 'A'+index into a small FIFO. The FIFO
// head is offered downstream with a valid/ready handshake. Malformed strobes (no lamp or
// several lamps) and letters lost to a full FIFO raise sticky error flags.
//
// Optional feature: define LAMP_READER_GROUP_SPACE_EN to split the output into five-letter
// groups separated by a single space (8'h20). When it is undefined, the output is letters only.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high reset
//   lamp         in   [25:0] lamp lines, bit i lit = letter 'A'+i
//   lamp_strobe  in   one-cycle pulse qualifying lamp
//   out_data     out  [7:0] ASCII at FIFO head, space while separating, 8'h00 when empty
//   out_valid    out  out_data holds a character to transfer
//   out_ready    in   downstream accepts out_data this cycle
//   err_onehot   out  sticky: strobe with zero or multiple lamps lit
//   err_overflow out  sticky: valid letter dropped on a full FIFO
//   char_count   out  [15:0] letters written into the FIFO, wrapping

module lamp_reader #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [25:0] lamp,
    input  logic        lamp_strobe,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err_onehot,
    output logic        err_overflow,
    output logic [15:0] char_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          err_onehot_q, err_onehot_d;
    logic          err_overflow_q, err_overflow_d;
    logic [15:0]   char_count_q, char_count_d;

    logic       lamp_onehot;
    logic [4:0] lamp_idx;
    logic [7:0] letter;
    logic       fifo_empty;
    logic       fifo_full;
    logic       push;
    logic       pop;
    logic [7:0] head;

    // Lamp decode: one-hot test via x & (x-1), index by priority scan.
    always_comb begin
        lamp_idx    = '0;
        lamp_onehot = (|lamp) && !(|(lamp & (lamp - 26'd1)));
        for (int i = 0; i < 26; i++) begin
            if (lamp[i]) begin
                lamp_idx = 5'(i);
            end
        end
        letter = 8'h41 + {3'b000, lamp_idx};
    end

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FullCnt);
    assign head       = mem_q[rd_ptr_q];

`ifdef LAMP_READER_GROUP_SPACE_EN
    typedef enum logic [0:0] {StLetter, StSpace} state_e;

    state_e     state_q, state_d;
    logic [2:0] grp_q, grp_d;

    // A space is only offered once the next letter is already queued, so there is never a
    // trailing space and never two in a row.
    always_comb begin
        out_valid = !fifo_empty;
        if (state_q == StSpace) begin
            out_data = 8'h20;
        end else begin
            out_data = fifo_empty ? 8'h00 : head;
        end
        pop = out_valid && out_ready && (state_q == StLetter);
    end

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        unique case (state_q)
            StLetter: begin
                if (pop) begin
                    if (grp_q == 3'd4) begin
                        state_d = StSpace;
                    end else begin
                        grp_d = grp_q + 3'd1;
                    end
                end
            end
            StSpace: begin
                if (out_valid && out_ready) begin
                    state_d = StLetter;
                    grp_d   = 3'd0;
                end
            end
            default: begin
                state_d = StLetter;
                grp_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StLetter;
            grp_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
        end
    end
`else
    always_comb begin
        out_valid = !fifo_empty;
        out_data  = fifo_empty ? 8'h00 : head;
        pop       = out_valid && out_ready;
    end
`endif

    // A full FIFO still takes a letter when the head leaves in the same cycle.
    assign push = lamp_strobe && lamp_onehot && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d       = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d       = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d          = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        err_onehot_d   = err_onehot_q | (lamp_strobe && !lamp_onehot);
        err_overflow_d = err_overflow_q | (lamp_strobe && lamp_onehot && fifo_full && !pop);
        char_count_d   = char_count_q + {15'd0, push};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            err_onehot_q   <= 1'b0;
            err_overflow_q <= 1'b0;
            char_count_q   <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
            err_onehot_q   <= err_onehot_d;
            err_overflow_q <= err_overflow_d;
            char_count_q   <= char_count_d;
        end
    end

    // Storage needs no reset; an empty FIFO never exposes it.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= letter;
        end
    end

    assign err_onehot   = err_onehot_q;
    assign err_overflow = err_overflow_q;
    assign char_count   = char_count_q;

endmodule

// File: tb/tb_lamp_reader.sv
module tb_lamp_reader;

    logic        clk;
    logic        reset;
    logic [25:0] lamp;
    logic        lamp_strobe;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        err_onehot;
    logic        err_overflow;
    logic [15:0] char_count;

    int n_checks;
    int n_bad;

    logic [7:0] stim_q [$];
    logic [7:0] got_q  [$];
    logic [7:0] exp_q  [$];

    lamp_reader #(.DEPTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .lamp         (lamp),
        .lamp_strobe  (lamp_strobe),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .err_onehot   (err_onehot),
        .err_overflow (err_overflow),
        .char_count   (char_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [25:0] lamp_of(input logic [7:0] c);
        lamp_of = 26'd1 << (c - 8'h41);
    endfunction

    task automatic strobe(input logic [25:0] l);
        lamp        = l;
        lamp_strobe = 1'b1;
        step();
        lamp_strobe = 1'b0;
        lamp        = '0;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        lamp_strobe = 1'b0;
        lamp        = '0;
        out_ready   = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Strobe stim_q one letter per cycle with out_ready held high; record every handshake.
    task automatic run_stream(input int cycles);
        got_q.delete();
        for (int c = 0; c < cycles; c++) begin
            if (stim_q.size() > 0) begin
                lamp_strobe = 1'b1;
                lamp        = lamp_of(stim_q.pop_front());
            end else begin
                lamp_strobe = 1'b0;
                lamp        = '0;
            end
            out_ready = 1'b1;
            if (out_valid) got_q.push_back(out_data);
            step();
        end
        lamp_strobe = 1'b0;
        lamp        = '0;
        out_ready   = 1'b0;
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        end
    endtask

    initial begin
        n_checks    = 0;
        n_bad       = 0;
        reset       = 1'b1;
        lamp        = '0;
        lamp_strobe = 1'b0;
        out_ready   = 1'b0;

        // Reset state.
        do_reset();
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_count", char_count, 16'd0);
        check("rst_eoh", err_onehot, 1'b0);
        check("rst_eov", err_overflow, 1'b0);

        // Single letter 'A', latency 1.
        strobe(26'h0000001);
        check("a_valid", out_valid, 1'b1);
        check("a_data", out_data, 8'h41);
        check("a_count", char_count, 16'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("a_pop_valid", out_valid, 1'b0);
        check("a_pop_data", out_data, 8'h00);

        // Lamp ignored without strobe; bad strobes flag err_onehot only.
        do_reset();
        lamp        = 26'h0000004;
        lamp_strobe = 1'b0;
        step();
        lamp = '0;
        check("nostb_valid", out_valid, 1'b0);
        check("nostb_count", char_count, 16'd0);
        check("nostb_eoh", err_onehot, 1'b0);
        strobe(26'h0000000);
        check("zero_eoh", err_onehot, 1'b1);
        strobe(26'h0000003);
        check("multi_eoh", err_onehot, 1'b1);
        check("multi_valid", out_valid, 1'b0);
        check("multi_count", char_count, 16'd0);
        check("multi_eov", err_overflow, 1'b0);
        strobe(26'h2000000);
        check("z_data", out_data, 8'h5A);
        check("z_eoh_sticky", err_onehot, 1'b1);

        // Overflow: 9 letters into depth 8, output held while not ready.
        do_reset();
        for (int i = 0; i < 9; i++) strobe(lamp_of(8'h41 + 8'(i)));
        check("ovf_count", char_count, 16'd8);
        check("ovf_eov", err_overflow, 1'b1);
        check("ovf_eoh", err_onehot, 1'b0);
        step();
        step();
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, 8'h41);
        stim_q.delete();
        run_stream(20);
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45,
`ifdef LAMP_READER_GROUP_SPACE_EN
                  8'h20,
`endif
                  8'h46, 8'h47, 8'h48};
        compare_stream("ovf_drain");
        check("ovf_eov_sticky", err_overflow, 1'b1);

        // Full FIFO accepts a strobe when a pop happens in the same cycle.
        do_reset();
        for (int i = 0; i < 8; i++) strobe(lamp_of(8'h41 + 8'(i)));
        check("full_count", char_count, 16'd8);
        lamp        = lamp_of(8'h5A);
        lamp_strobe = 1'b1;
        out_ready   = 1'b1;
        step();
        lamp_strobe = 1'b0;
        lamp        = '0;
        out_ready   = 1'b0;
        check("fullpop_eov", err_overflow, 1'b0);
        check("fullpop_count", char_count, 16'd9);
        check("fullpop_head", out_data, 8'h42);
        run_stream(20);
`ifdef LAMP_READER_GROUP_SPACE_EN
        exp_q = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h20, 8'h46, 8'h47, 8'h48, 8'h5A};
`else
        exp_q = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h5A};
`endif
        compare_stream("fullpop_drain");

        // HELLOW stream.
        do_reset();
        stim_q = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h57};
        run_stream(20);
`ifdef LAMP_READER_GROUP_SPACE_EN
        exp_q = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h57};
`else
        exp_q = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h57};
`endif
        compare_stream("hellow");
        check("hellow_count", char_count, 16'd6);

        // HELLO alone: no trailing space; a later letter gets its separator first.
        do_reset();
        stim_q = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        run_stream(15);
        exp_q = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        compare_stream("hello");
        check("hello_idle_valid", out_valid, 1'b0);
        stim_q = '{8'h57};
        run_stream(6);
`ifdef LAMP_READER_GROUP_SPACE_EN
        exp_q = '{8'h20, 8'h57};
`else
        exp_q = '{8'h57};
`endif
        compare_stream("late_w");

        // Reset wins over queued letters, a strobe and a handshake in the same cycle.
        do_reset();
        for (int i = 0; i < 3; i++) strobe(lamp_of(8'h41 + 8'(i)));
        strobe(26'h0000000);
        check("pre_rst_count", char_count, 16'd3);
        check("pre_rst_eoh", err_onehot, 1'b1);
        reset       = 1'b1;
        lamp        = lamp_of(8'h51);
        lamp_strobe = 1'b1;
        out_ready   = 1'b1;
        step();
        reset       = 1'b0;
        lamp_strobe = 1'b0;
        lamp        = '0;
        out_ready   = 1'b0;
        check("rst3_valid", out_valid, 1'b0);
        check("rst3_data", out_data, 8'h00);
        check("rst3_count", char_count, 16'd0);
        check("rst3_eoh", err_onehot, 1'b0);
        check("rst3_eov", err_overflow, 1'b0);
        step();
        check("rst3_after_valid", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
